// File: rtl/button_event_scheduler.sv
// Serialises single-cycle button pulses into an ordered event queue using round-robin arbitration.
// Optional feature macro: BTN_SCHED_DROP_CNT_EN adds the saturating drop_cnt output.
module button_event_scheduler #(
   parameter int N_BTN      = 5,
   parameter int CODE_W     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_BTN-1:0]              btn_pulse,
   input  logic                          accept_en,
   input  logic                          flush,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [CODE_W-1:0]             evt_code,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow
`ifdef BTN_SCHED_DROP_CNT_EN
   ,
   output logic [DROP_W-1:0]             drop_cnt
`endif
);

   localparam int PTR_W = $clog2(N_BTN);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   logic [N_BTN-1:0]  r_pending;
   logic [PTR_W-1:0]  r_rr_ptr;
   logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;

   logic              w_found;
   logic [PTR_W-1:0]  w_gidx;
   logic              w_open;
   logic              w_pop;
   logic              w_push;
   logic [N_BTN-1:0]  w_grant;
   logic [N_BTN-1:0]  w_drop;
   logic [N_BTN-1:0]  w_pending_nxt;

   // Handshake: the head transfers on any rising edge where evt_valid && evt_ready;
   // evt_code holds steady while evt_valid is high and evt_ready is low.
   assign evt_valid = (r_count != '0);
   assign evt_code  = evt_valid ? r_mem[r_rd_ptr] : '0;
   assign evt_count = r_count;
   assign overflow  = r_overflow;

   // Round-robin search starting at r_rr_ptr, wrapping from N_BTN-1 to 0.
   always_comb begin : arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < N_BTN; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_BTN) idx = idx - N_BTN;
         if (!w_found && r_pending[idx]) begin
            w_found = 1'b1;
            w_gidx  = PTR_W'(idx);
         end
      end
   end

   assign w_open = accept_en & ~flush;
   assign w_pop  = evt_valid & evt_ready;
   assign w_push = w_found & w_open & ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         w_grant[i] = w_push && (w_gidx == PTR_W'(i));
      end
   end

   // A re-pulse on a button that is granted this cycle is kept as a fresh pending request.
   assign w_drop        = w_open ? (btn_pulse & r_pending & ~w_grant) : '0;
   assign w_pending_nxt = w_open ? ((r_pending & ~w_grant) | btn_pulse) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending  <= '0;
         r_rr_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending  <= w_pending_nxt;
         r_overflow <= |w_drop;
         if (w_push) begin
            r_rr_ptr <= (w_gidx == PTR_W'(N_BTN - 1)) ? '0 : w_gidx + 1'b1;
         end
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= CODE_W'(w_gidx);
   end

`ifdef BTN_SCHED_DROP_CNT_EN
   localparam int DN_W = $clog2(N_BTN + 1);

   logic [DROP_W-1:0] r_drop_cnt;
   logic [DN_W-1:0]   w_drop_num;
   logic [DROP_W:0]   w_drop_sum;

   always_comb begin
      w_drop_num = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_drop_num = w_drop_num + DN_W'(w_drop[i]);
      end
   end

   assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W + 1)'(w_drop_num);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (w_drop_sum[DROP_W]) begin
         r_drop_cnt <= '1;
      end else begin
         r_drop_cnt <= w_drop_sum[DROP_W-1:0];
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule
